// File: rtl/vga_scan_timing.sv
// VGA scan timing: pixel-tick divider, h/v counters, pixel request and registered RGB565 output stage.
// Latency: one pixel (CLK_DIV clk) from request to pins; request stable CLK_DIV clk after each tick.
// Backpressure: none; the upstream pixel source must answer within CLK_DIV-1 clk of a request change.
module vga_scan_timing #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HS_ACTIVE = 1'b0,
  parameter bit VS_ACTIVE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        pix_tick,
  output logic [9:0]  req_x,
  output logic [9:0]  req_y,
  output logic        req_valid,
  input  logic [15:0] pixel_in,
  output logic [4:0]  red,
  output logic [5:0]  green,
  output logic [4:0]  blue,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic          h_sync_on;
  logic          v_sync_on;

  // With CLK_DIV == 1 the divider stays at zero and the tick is permanently high.
  assign pix_tick  = (div == DW'(CLK_DIV - 1));
  assign req_x     = hcnt;
  assign req_y     = vcnt;
  assign req_valid = (hcnt < 10'(H_VISIBLE)) && (vcnt < 10'(V_VISIBLE));
  assign h_sync_on = (hcnt >= 10'(H_VISIBLE + H_FRONT)) &&
                     (hcnt <  10'(H_VISIBLE + H_FRONT + H_SYNC));
  assign v_sync_on = (vcnt >= 10'(V_VISIBLE + V_FRONT)) &&
                     (vcnt <  10'(V_VISIBLE + V_FRONT + V_SYNC));

  // Clock divider producing the one-clk pixel tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (pix_tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Horizontal/vertical scan counters; both wrap on the same tick at end of frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_tick) begin
      if (hcnt == 10'(H_TOTAL - 1)) begin
        hcnt <= '0;
        vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end
    end
  end

  // Output stage: latch syncs, enable and blanked colour of the current request on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      de          <= 1'b0;
      hs          <= ~HS_ACTIVE;
      vs          <= ~VS_ACTIVE;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes mark the first clk in which column 0 (and row 0) appears on the pins.
      line_start  <= pix_tick && (hcnt == 10'd0);
      frame_start <= pix_tick && (hcnt == 10'd0) && (vcnt == 10'd0);
      if (pix_tick) begin
        de <= req_valid;
        hs <= h_sync_on ? HS_ACTIVE : ~HS_ACTIVE;
        vs <= v_sync_on ? VS_ACTIVE : ~VS_ACTIVE;
        if (req_valid) begin
          {red, green, blue} <= pixel_in;
        end else begin
          {red, green, blue} <= 16'h0000;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: default-timing instance for reset/line checks, small-timing instance for frames.
// Small instance: CLK_DIV=3, 12 px/line (6 visible), 8 lines (4 visible), hs active-high, vs active-low.
// Pixel source for the small instance answers with one clk of latency.
module tb_vga_scan_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        tick_a, rv_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic [9:0]  rx_a, ry_a;
  logic [15:0] pin_a;
  logic [4:0]  r_a, b_a;
  logic [5:0]  g_a;
  logic        tick_b, rv_b, hs_b, vs_b, de_b, ls_b, fs_b;
  logic [9:0]  rx_b, ry_b;
  logic [15:0] pin_b;
  logic [4:0]  r_b, b_b;
  logic [5:0]  g_b;

  int errors = 0;
  int checks = 0;

  vga_scan_timing dut_a (
    .clk(clk), .reset(rst_a), .pix_tick(tick_a), .req_x(rx_a), .req_y(ry_a),
    .req_valid(rv_a), .pixel_in(pin_a), .red(r_a), .green(g_a), .blue(b_a),
    .hs(hs_a), .vs(vs_a), .de(de_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_scan_timing #(
    .CLK_DIV(3), .H_VISIBLE(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_ACTIVE(1'b1), .VS_ACTIVE(1'b0)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_tick(tick_b), .req_x(rx_b), .req_y(ry_b),
    .req_valid(rv_b), .pixel_in(pin_b), .red(r_b), .green(g_b), .blue(b_b),
    .hs(hs_b), .vs(vs_b), .de(de_b), .line_start(ls_b), .frame_start(fs_b)
  );

  // Upstream source model with one clk of read latency.
  always @(posedge clk) pin_b <= {rx_b[4:0], ry_b[5:0], rx_b[9:5]};

  typedef struct {
    int   k;
    logic tick;
    int   rx;
    int   ry;
    logic rv;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl[NV];

  function automatic vec_t mk(input int k, input logic t, input int rx, input int ry,
                              input logic rv, input logic de, input logic hs,
                              input logic vs, input logic ls, input logic fs);
    vec_t v;
    v.k = k; v.tick = t; v.rx = rx; v.ry = ry; v.rv = rv;
    v.de = de; v.hs = hs; v.vs = vs; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_b(input string tag);
    check({tag, " tick"}, {31'd0, tick_b}, 0);
    check({tag, " req"}, {12'd0, rx_b, ry_b}, 0);
    check({tag, " de/ls/fs"}, {29'd0, de_b, ls_b, fs_b}, 0);
    check({tag, " hs"}, {31'd0, hs_b}, 0);
    check({tag, " vs"}, {31'd0, vs_b}, 1);
    check({tag, " rgb"}, {16'd0, r_b, g_b, b_b}, 0);
  endtask

  // Runs the small instance for nk windows after reset release; window k is #1 after release edge k.
  task automatic run_b(input int nk, input bit measure);
    int ti, m, p, x, y, fs0, fs1, vs_first, vs_cnt, de_ticks;
    logic [15:0] exp_rgb;
    logic [9:0]  xv, yv;
    ti = 0; fs0 = -1; fs1 = -1; vs_first = -1; vs_cnt = 0; de_ticks = 0;
    for (int k = 0; k < nk; k++) begin
      @(posedge clk); #1;
      if (ti < NV && tbl[ti].k == k) begin
        check($sformatf("b k=%0d tick", k), {31'd0, tick_b}, {31'd0, tbl[ti].tick});
        check($sformatf("b k=%0d req_x", k), {22'd0, rx_b}, tbl[ti].rx);
        check($sformatf("b k=%0d req_y", k), {22'd0, ry_b}, tbl[ti].ry);
        check($sformatf("b k=%0d req_valid", k), {31'd0, rv_b}, {31'd0, tbl[ti].rv});
        check($sformatf("b k=%0d de/hs/vs/ls/fs", k), {27'd0, de_b, hs_b, vs_b, ls_b, fs_b},
              {27'd0, tbl[ti].de, tbl[ti].hs, tbl[ti].vs, tbl[ti].ls, tbl[ti].fs});
        ti++;
      end
      // Pixel shown in window k is the one loaded by the most recent applied tick.
      m = (k < 2) ? 0 : (k - 2) / 3 + 1;
      exp_rgb = 16'h0000;
      if (m > 0) begin
        p = m - 1;
        x = p % 12;
        y = (p / 12) % 8;
        xv = 10'(x);
        yv = 10'(y);
        if (x < 6 && y < 4) exp_rgb = {xv[4:0], yv[5:0], xv[9:5]};
      end
      check($sformatf("b k=%0d rgb", k), {16'd0, r_b, g_b, b_b}, {16'd0, exp_rgb});
      if (measure) begin
        if (fs_b) begin
          if (fs0 < 0) fs0 = k;
          else if (fs1 < 0) fs1 = k;
        end
        if (fs0 >= 0 && fs1 < 0) begin
          if (!vs_b) begin
            vs_cnt++;
            if (vs_first < 0) vs_first = k;
          end
          if (de_b && tick_b) de_ticks++;
        end
      end
    end
    if (measure) begin
      check("b frame_start period", fs1 - fs0, 288);
      check("b vs low offset", vs_first - fs0, 180);
      check("b vs low clk", vs_cnt, 72);
      check("b de pixels per frame", de_ticks, 24);
    end
  endtask

  initial begin
    int first_tick, last_tick, bad_per, ls0, ls1, hs_first, hs_cnt, de_cnt, bad_rgb, found;

    tbl[0]  = mk(0,   1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[1]  = mk(1,   1'b1, 0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(2,   1'b0, 1,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tbl[3]  = mk(3,   1'b0, 1,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(4,   1'b1, 1,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[5]  = mk(5,   1'b0, 2,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mk(19,  1'b1, 6,  0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[7]  = mk(20,  1'b0, 7,  0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[8]  = mk(26,  1'b0, 9,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[9]  = mk(32,  1'b0, 11, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[10] = mk(35,  1'b0, 0,  1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[11] = mk(38,  1'b0, 1,  1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[12] = mk(182, 1'b0, 1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(218, 1'b0, 1,  6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[14] = mk(254, 1'b0, 1,  7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tbl[15] = mk(287, 1'b0, 0,  0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[16] = mk(290, 1'b0, 1,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    pin_a = 16'hFFFF;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("a reset tick", {31'd0, tick_a}, 0);
    check("a reset req", {12'd0, rx_a, ry_a}, 0);
    check("a reset de/ls/fs", {29'd0, de_a, ls_a, fs_a}, 0);
    check("a reset hs/vs", {30'd0, hs_a, vs_a}, 3);
    check("a reset rgb", {16'd0, r_a, g_a, b_a}, 0);
    check_reset_b("b reset");

    // Default-timing instance: one full line after reset release.
    rst_a = 1'b0;
    first_tick = -1; last_tick = -1; bad_per = 0; ls0 = -1; ls1 = -1;
    hs_first = -1; hs_cnt = 0; de_cnt = 0; bad_rgb = 0;
    for (int k = 0; k < 3300; k++) begin
      @(posedge clk); #1;
      if (first_tick >= 0 && k == first_tick + 1) begin
        check("a ls/fs after first tick", {30'd0, ls_a, fs_a}, 3);
        check("a req_x after first tick", {22'd0, rx_a}, 1);
      end
      if (tick_a) begin
        if (first_tick < 0) first_tick = k;
        if (last_tick >= 0 && k - last_tick != 4) bad_per++;
        last_tick = k;
      end
      if (ls_a) begin
        if (ls0 < 0) ls0 = k;
        else if (ls1 < 0) ls1 = k;
      end
      if (ls0 >= 0 && ls1 < 0) begin
        if (de_a) de_cnt++;
        if (!hs_a) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = k;
        end
      end
      if ({r_a, g_a, b_a} !== (de_a ? 16'hFFFF : 16'h0000)) bad_rgb++;
    end
    check("a first tick window", first_tick, 2);
    check("a tick period errors", bad_per, 0);
    check("a line_start period", ls1 - ls0, 3200);
    check("a hs low offset", hs_first - ls0, 2624);
    check("a hs low clk", hs_cnt, 384);
    check("a de clk per line", de_cnt, 2560);
    check("a rgb blanking errors", bad_rgb, 0);

    // Small-timing instance: two frames from reset release.
    rst_b = 1'b0;
    run_b(600, 1'b1);

    // Mid-frame single-clk reset, then restart must match the first release.
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(posedge clk); #1;
      if (rx_b == 10'd7 && ry_b == 10'd2) found = 1;
    end
    check("b reached hcnt=7 vcnt=2", found, 1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_reset_b("b mid reset");
    rst_b = 1'b0;
    run_b(40, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Scan-timing and pixel-pipeline stage that drives the board VGA pins: vga_red[4:0], vga_green[5:0], vga_blue[4:0], vga_hs and vga_vs.
- Derives a pixel tick from the 100 MHz board clock and runs horizontal/vertical counters (default 640x480@60, 25 MHz pixel rate).
- Publishes the coordinate of the pixel it needs next and registers the RGB565 word returned by the upstream pixel source, which is text renderer or framebuffer logic.
- Blanks colour outside the visible area and emits line/frame strobes for upstream sequencing.

Parameters:
CLK_DIV, 4, clk cycles per pixel (>=1; 1 means pix_tick is constantly high)
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
HS_ACTIVE, 0, level of hs during sync pulse
VS_ACTIVE, 0, level of vs during sync pulse

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
pix_tick  output  1  one-clk pixel-advance strobe
req_x  output  10  horizontal counter (pixel wanted next)
req_y  output  10  vertical counter
req_valid  output  1  req_x/req_y lie in the visible area
pixel_in  input  16  RGB565 for (req_x,req_y); sampled on pix_tick
red  output  5  pixel_in[15:11] when de, else 0
green  output  6  pixel_in[10:5] when de, else 0
blue  output  5  pixel_in[4:0] when de, else 0
hs  output  1  horizontal sync
vs  output  1  vertical sync
de  output  1  display enable, aligned with red/green/blue
line_start  output  1  one-clk pulse at start of each output line
frame_start  output  1  one-clk pulse at start of each output frame

Behaviour:
- One clock domain: clk. reset is synchronous and active-high; it is sampled on the rising edge of clk.

Pixel tick divider and counters:
- div counts 0..CLK_DIV-1; pix_tick = (div == CLK_DIV-1).
- H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525). Both must be <= 1024; the widths are not checked in RTL.
- hcnt and vcnt are registers and advance only on pix_tick:
  - hcnt wraps H_TOTAL-1 -> 0.
  - vcnt increments when hcnt wraps and itself wraps V_TOTAL-1 -> 0.
- req_x = hcnt, req_y = vcnt, req_valid = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- The request changes in the clk after a tick and stays stable for CLK_DIV cycles. The upstream source may use up to CLK_DIV-1 cycles of read latency.

Output stage (updates only on pix_tick; registered, so one pixel of latency):
- de <= req_valid.
- hs <= HS_ACTIVE if H_VISIBLE+H_FRONT <= hcnt < H_VISIBLE+H_FRONT+H_SYNC, else ~HS_ACTIVE.
- vs <= VS_ACTIVE if V_VISIBLE+V_FRONT <= vcnt < V_VISIBLE+V_FRONT+V_SYNC, else ~VS_ACTIVE.
- {red,green,blue} <= req_valid ? pixel_in : 0. pixel_in is ignored when req_valid = 0.
- line_start is high for exactly the one clk after a tick where hcnt == 0, i.e. the cycle in which the outputs first show column 0.
- frame_start is high for the one clk after a tick where hcnt == 0 && vcnt == 0.
- Between ticks, every output-stage signal holds its value.

Reset values (next cycle after reset is sampled high; also applies mid-frame):
- div, hcnt, vcnt = 0.
- de = 0; red, green, blue = 0.
- hs = ~HS_ACTIVE; vs = ~VS_ACTIVE.
- line_start = 0; frame_start = 0.
- First pix_tick occurs CLK_DIV-1 cycles after reset deasserts. That tick loads pixel (0,0), and frame_start/line_start pulse in the following cycle.

Boundary rules:
- hcnt wrap and vcnt wrap fall on the same tick at the end of a frame.
- If reset and pix_tick coincide, reset wins.
- Defaults give: line = 3200 clk; frame = 1,680,000 clk; 307,200 de-high pixels per frame.

Test Plan:
- Reset held 10 clk then released -> all outputs at reset values during reset; hs = vs = 1; first pix_tick 3 clk after release; frame_start and line_start high in the next clk; req_x = 1 after that tick.
- Free-run one line -> pix_tick period 4 clk; hs low for exactly 384 clk, starting 2624 clk after line_start; line_start period 3200 clk; de high 2560 clk per visible line.
- Free-run two frames -> frame_start period 1,680,000 clk; vs low for exactly 2 lines (6400 clk), beginning at line 490; de-high pixel count = 307,200 per frame.
- pixel_in driven as {req_x[4:0], req_y[5:0], req_x[9:5]} with 1-clk latency -> at every de-high tick red/green/blue equal the values for the previously requested (x,y), with no off-by-one at x = 0, x = 639, y = 479.
- pixel_in held at 16'hFFFF -> red/green/blue = 0 whenever de = 0 (porches, sync, vertical blank); = 1F/3F/1F whenever de = 1.
- reset asserted for 1 clk at hcnt = 400, vcnt = 200 -> next cycle all counters and outputs are at reset values; restart timing identical to the first scenario.
